fetch_pc_ctrl: RTL

//  Instruction-fetch sequencer for the pipelined RV32 core. Owns the fetch PC register and picks next PC:

---
 rtl/fetch_pc_ctrl_pkg.sv | 20 ++
 rtl/fetch_pc_ctrl_if.sv | 11 +
 rtl/fetch_pc_ctrl_pc_redirect_mux.sv | 25 ++
 rtl/fetch_pc_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM states, NOP word,
// default trap vector and the PC increment helper.
package fetch_pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

  // 32-bit modulo increment; FFFF_FFFC wraps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-memory port: one outstanding req/gnt/rvalid transaction.
interface fetch_pc_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_pc_ctrl_pc_redirect_mux.sv
// Redirect detect and priority target select (trap > jalr > branch), word-aligned.
import fetch_pc_ctrl_pkg::*;

module pc_redirect_mux #(
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic        trap_i,
  input  logic        jalr_i,
  input  logic        br_i,
  input  logic [31:0] jalr_tgt_i,
  input  logic [31:0] br_tgt_i,
  output logic        redirect_o,
  output logic [31:0] target_o
);
  logic [31:0] raw;

  always_comb begin
    raw = br_tgt_i;
    if (jalr_i) raw = jalr_tgt_i;
    if (trap_i) raw = TRAP_VEC;
  end

  assign redirect_o = trap_i | jalr_i | br_i;
  assign target_o   = raw & ~32'h0000_0003;
endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: owns the fetch PC, issues one fetch at a time and fills
// the IF/ID slot, discarding responses that belong to squashed fetches.
import fetch_pc_ctrl_pkg::*;

module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               trap_i,
  input  logic               jalr_e_i,
  input  logic [31:0]        jalr_tgt_i,
  input  logic               br_taken_e_i,
  input  logic [31:0]        br_tgt_i,
  fetch_pc_ctrl_if.master    imem,
  output logic               if_valid_o,
  output logic [31:0]        if_pc_o,
  output logic [31:0]        if_instr_o,
  output logic [31:0]        if_pcplus4_o,
  output logic               flush_d_o,
  output logic [31:0]        pc_o
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fpc_q, fpc_d;       // PC of the fetch currently outstanding
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         redirect, req, fire, load;
  logic [31:0]  target;

  pc_redirect_mux #(.TRAP_VEC(TRAP_VEC)) u_mux (
    .trap_i     (trap_i),
    .jalr_i     (jalr_e_i),
    .br_i       (br_taken_e_i),
    .jalr_tgt_i (jalr_tgt_i),
    .br_tgt_i   (br_tgt_i),
    .redirect_o (redirect),
    .target_o   (target)
  );

  // Don't fetch while a stalled, valid instruction occupies IF/ID: there'd be nowhere to put it.
  assign req  = (state_q == ST_REQ) && !(if_valid_q && stall_i);
  assign fire = req && imem.gnt;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fpc_d   = fpc_q;
    load    = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        if (redirect) begin
          pc_d = target;
          if (fire) state_d = ST_DROP;
        end else if (fire) begin
          pc_d    = pc_plus4(pc_q);
          fpc_d   = pc_q;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (redirect) begin
          pc_d    = target;
          state_d = imem.rvalid ? ST_REQ : ST_DROP;
        end else if (imem.rvalid) begin
          load    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect)    pc_d    = target;
        if (imem.rvalid) state_d = ST_REQ;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if (load) begin
      if_valid_d = 1'b1;
      if_pc_d    = fpc_q;
      if_instr_d = imem.rdata;
    end else if (redirect || !stall_i) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      fpc_q      <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fpc_q      <= fpc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem.req     = req;
  assign imem.addr    = pc_q;
  assign pc_o         = pc_q;
  assign flush_d_o    = redirect;
  assign if_valid_o   = if_valid_q;
  assign if_pc_o      = if_pc_q;
  assign if_instr_o   = if_instr_q;
  assign if_pcplus4_o = pc_plus4(if_pc_q);

  a_no_rvalid_when_held: assert property (@(posedge clk) disable iff (rst)
    !(imem.rvalid && if_valid_q && stall_i));

endmodule
